// File: rtl/lbuf_pkg.sv
// ---------------------------------------------------------------------------
// lbuf_pkg
// Shared definitions for the lbuf path: the scheduler state encoding, the
// 4 KB host page size and the set of legal max-payload sizes. The lbuf
// hand-out FSM and the TLP generator import the same package.
// ---------------------------------------------------------------------------
package lbuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC1 = 3'd1,
        ST_CALC2 = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4,
        ST_DRAIN = 3'd5
    } lbuf_state_e;

    localparam int unsigned PAGE_BYTES    = 4096;
    localparam int unsigned MPS_MIN_BYTES = 128;
    localparam int unsigned MPS_MAX_BYTES = 512;

    // A max payload size is legal when it is a power of two in 128..512.
    function automatic bit mps_is_legal(input int unsigned mps);
        return (mps == 128) || (mps == 256) || (mps == 512);
    endfunction

endpackage

// File: rtl/lbuf_chunk_calc.sv
// ---------------------------------------------------------------------------
// lbuf_chunk_calc
// Two-stage size pipeline for one memory-write request.
//   Stage 1 (registered on c1_load_i): c1 = min(remain, MPS, bytes left in
//   the current 4 KB page).
//   Stage 2 (combinational on c1_q): chunk = min(c1, avail_qw*8).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   c1_load_i       capture stage-1 result (scheduler is in CALC1)
//   remain_i        bytes still to schedule (qword multiple)
//   cur_addr_lo_i   low 12 bits of the next request address
//   avail_qw_i      qwords staged in the RX packet buffer
//   avail_zero_o    nothing staged; scheduler must wait
//   chunk_o         size in bytes of the request to issue
// ---------------------------------------------------------------------------
module lbuf_chunk_calc
    import lbuf_pkg::*;
#(
    parameter int unsigned MPS_BYTES = 128,
    parameter int unsigned AVAIL_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               c1_load_i,
    input  logic [31:0]        remain_i,
    input  logic [11:0]        cur_addr_lo_i,
    input  logic [AVAIL_W-1:0] avail_qw_i,
    output logic               avail_zero_o,
    output logic [31:0]        chunk_o
);

    // Compare width wide enough for both the staged count and c1 in qwords.
    localparam int unsigned CW = (AVAIL_W > 32) ? AVAIL_W : 32;

    logic [12:0]   page_room;
    logic [31:0]   c1_d;
    logic [31:0]   c1_q;
    logic [CW-1:0] avail_ext;
    logic [CW-1:0] c1_qw;

    // cur_addr is qword aligned, so page_room lies in 8..4096.
    // NOTE: every variable driven in always_comb gets a value on every path
    // (here the first statement), otherwise synthesis infers a latch.
    always_comb begin
        page_room = 13'(PAGE_BYTES) - {1'b0, cur_addr_lo_i};
        c1_d      = remain_i;
        if (c1_d > 32'(MPS_BYTES)) c1_d = 32'(MPS_BYTES);
        if (c1_d > 32'(page_room)) c1_d = 32'(page_room);
    end

    // NOTE: rst is synchronous, so it is tested inside the clocked block and
    // is not in the sensitivity list; state uses non-blocking assignments so
    // every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            c1_q <= '0;
        end else if (c1_load_i) begin
            c1_q <= c1_d;
        end
    end

    // min(c1, avail*8) without a saturating multiply: c1 is a qword multiple
    // of at most 512 B, so when avail_qw is below c1/8 the product fits.
    assign avail_ext    = CW'(avail_qw_i);
    assign c1_qw        = CW'(c1_q[31:3]);
    assign avail_zero_o = (avail_qw_i == '0);

    always_comb begin
        if (avail_ext >= c1_qw) chunk_o = c1_q;
        else                    chunk_o = 32'(avail_ext) << 3;
    end

endmodule

// File: rtl/lbuf_wr_sched.sv
// ---------------------------------------------------------------------------
// lbuf_wr_sched
// Splits a granted large host buffer (lbuf) into PCIe memory-write requests.
// Each request is capped by max payload size, the 4 KB page boundary and the
// data already staged in the RX packet buffer. lbuf_dn_o returns the lbuf
// once the final request has been accepted.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   lbuf_addr_i       lbuf base byte address ([2:0] ignored)
//   lbuf_len_i        lbuf length in bytes ([2:0] ignored)
//   lbuf_en_i         lbuf valid level, held until after lbuf_dn_o
//   lbuf64b_i         address needs a 64-bit TLP header
//   lbuf_dn_o         one-cycle pulse: lbuf fully scheduled
//   avail_qw_i        qwords staged and not yet committed
//   commit_qw_o       qwords consumed by the accepted request
//   commit_en_o       one-cycle pulse on request acceptance
//   req_valid_o/req_ready_i   request handshake to the TLP generator
//   req_addr_o        request byte address
//   req_len_dw_o      payload length in dwords (always even)
//   req_64b_o         lbuf64b_i captured at grant
//   req_last_o        final request of this lbuf
//   busy_o            lbuf held, from grant until the drain completes
// ---------------------------------------------------------------------------
module lbuf_wr_sched
    import lbuf_pkg::*;
#(
    parameter int unsigned MPS_BYTES = 128,
    parameter int unsigned AVAIL_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        lbuf_addr_i,
    input  logic [31:0]        lbuf_len_i,
    input  logic               lbuf_en_i,
    input  logic               lbuf64b_i,
    output logic               lbuf_dn_o,
    input  logic [AVAIL_W-1:0] avail_qw_i,
    output logic [9:0]         commit_qw_o,
    output logic               commit_en_o,
    output logic               req_valid_o,
    input  logic               req_ready_i,
    output logic [63:0]        req_addr_o,
    output logic [9:0]         req_len_dw_o,
    output logic               req_64b_o,
    output logic               req_last_o,
    output logic               busy_o
);

    if (!mps_is_legal(MPS_BYTES)) begin : g_bad_mps
        $error("lbuf_wr_sched: MPS_BYTES must be 128, 256 or 512");
    end

    lbuf_state_e state_q;
    logic [63:0] cur_addr_q;
    logic [31:0] remain_q;
    logic [31:0] chunk_q;
    logic        lbuf_dn_q;
    logic [9:0]  commit_qw_q;
    logic        commit_en_q;
    logic        req_valid_q;
    logic [63:0] req_addr_q;
    logic [9:0]  req_len_dw_q;
    logic        req_64b_q;
    logic        req_last_q;
    logic        busy_q;

    logic        avail_zero;
    logic [31:0] chunk;

    // Addresses and lengths are qword granular; the low bits are dropped.
    logic        unused_lsbs;
    assign unused_lsbs = ^{lbuf_addr_i[2:0], lbuf_len_i[2:0]};

    lbuf_chunk_calc #(
        .MPS_BYTES (MPS_BYTES),
        .AVAIL_W   (AVAIL_W)
    ) u_chunk_calc (
        .clk           (clk),
        .rst           (rst),
        .c1_load_i     (state_q == ST_CALC1),
        .remain_i      (remain_q),
        .cur_addr_lo_i (cur_addr_q[11:0]),
        .avail_qw_i    (avail_qw_i),
        .avail_zero_o  (avail_zero),
        .chunk_o       (chunk)
    );

    // lbuf_en_i dropping outside IDLE/DRAIN is a protocol violation; the FSM
    // ignores it there and finishes the lbuf it already owns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            remain_q     <= '0;
            chunk_q      <= '0;
            lbuf_dn_q    <= 1'b0;
            commit_qw_q  <= '0;
            commit_en_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_len_dw_q <= '0;
            req_64b_q    <= 1'b0;
            req_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            lbuf_dn_q   <= 1'b0;
            commit_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (lbuf_en_i) begin
                        cur_addr_q <= {lbuf_addr_i[63:3], 3'b000};
                        remain_q   <= {lbuf_len_i[31:3], 3'b000};
                        req_64b_q  <= lbuf64b_i;
                        busy_q     <= 1'b1;
                        if (lbuf_len_i[31:3] == '0) begin
                            // lbuf_dn is registered, so it rises on entry to DONE.
                            lbuf_dn_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q   <= ST_CALC1;
                        end
                    end
                end
                ST_CALC1: state_q <= ST_CALC2;
                ST_CALC2: begin
                    // Re-sample avail_qw every cycle until data is staged.
                    if (!avail_zero) begin
                        chunk_q      <= chunk;
                        req_addr_q   <= cur_addr_q;
                        req_len_dw_q <= chunk[11:2];
                        req_last_q   <= (chunk == remain_q);
                        req_valid_q  <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (req_ready_i) begin
                        req_valid_q <= 1'b0;
                        commit_en_q <= 1'b1;
                        commit_qw_q <= chunk_q[12:3];
                        cur_addr_q  <= cur_addr_q + 64'(chunk_q);
                        remain_q    <= remain_q - chunk_q;
                        if (req_last_q) begin
                            lbuf_dn_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q   <= ST_CALC1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    // Hold busy until the grant is withdrawn so the stale lbuf
                    // is not picked up again from IDLE.
                    if (!lbuf_en_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign lbuf_dn_o    = lbuf_dn_q;
    assign commit_qw_o  = commit_qw_q;
    assign commit_en_o  = commit_en_q;
    assign req_valid_o  = req_valid_q;
    assign req_addr_o   = req_addr_q;
    assign req_len_dw_o = req_len_dw_q;
    assign req_64b_o    = req_64b_q;
    assign req_last_o   = req_last_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_lbuf_wr_sched.sv
// ---------------------------------------------------------------------------
// tb_lbuf_wr_sched
// Self-checking bench for lbuf_wr_sched. A reference model tracks the next
// address and remaining bytes of the lbuf and predicts each request as
// min(remain, MPS, page room, staged*8); the bench also plays the staging
// buffer (avail_qw) and the TLP generator (req_ready).
// ---------------------------------------------------------------------------
module tb_lbuf_wr_sched;

    localparam int unsigned MPS = 128;
    localparam int unsigned AW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   lbuf_addr;
    logic [31:0]   lbuf_len;
    logic          lbuf_en;
    logic          lbuf64b;
    logic          lbuf_dn;
    logic [AW-1:0] avail_qw;
    logic [9:0]    commit_qw;
    logic          commit_en;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_addr;
    logic [9:0]    req_len_dw;
    logic          req_64b;
    logic          req_last;
    logic          busy;

    always #5 clk = ~clk;

    lbuf_wr_sched #(.MPS_BYTES(MPS), .AVAIL_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .lbuf_addr_i  (lbuf_addr),
        .lbuf_len_i   (lbuf_len),
        .lbuf_en_i    (lbuf_en),
        .lbuf64b_i    (lbuf64b),
        .lbuf_dn_o    (lbuf_dn),
        .avail_qw_i   (avail_qw),
        .commit_qw_o  (commit_qw),
        .commit_en_o  (commit_en),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .req_addr_o   (req_addr),
        .req_len_dw_o (req_len_dw),
        .req_64b_o    (req_64b),
        .req_last_o   (req_last),
        .busy_o       (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    int unsigned staged;       // qwords held by the modelled staging buffer
    logic [63:0] log_addr[$];
    int          log_len[$];
    bit          log_last[$];
    bit          log_64b[$];
    int          log_rise[$];
    int          log_acc[$];
    int          first_rise;
    int          n_commit;
    int          n_dn;

    // Reference request size from the lbuf rules.
    function automatic longint unsigned model_chunk(input logic [63:0] cur,
                                                    input longint unsigned remain,
                                                    input longint unsigned avail);
        longint unsigned c;
        longint unsigned room;
        c    = remain;
        room = 4096 - (cur % 4096);
        if (MPS < c)       c = MPS;
        if (room < c)      c = room;
        if (avail * 8 < c) c = avail * 8;
        return c;
    endfunction

    // Run one lbuf to completion, checking every cycle against the model.
    task automatic run_lbuf(input logic [63:0] addr, input logic [31:0] len,
                            input bit is64, input int ready_pct, input int hold,
                            input int prod_pct, input int starve);
        logic [63:0]     m_cur;
        longint unsigned m_remain;
        longint unsigned chunk = 0;
        bit              exp_last = 0;
        bit              dn_next;
        bit              commit_next = 0;
        int unsigned     commit_exp = 0;
        bit              prev_valid = 0;
        bit              prev_ready = 0;
        logic [63:0]     p_addr = '0;
        logic [9:0]      p_len = '0;
        bit              p_last = 0;
        bit              p_64 = 0;
        int unsigned     avail_prev;
        int              hold_left = hold;
        bit              done = 0;
        int              cyc = 0;
        log_addr.delete(); log_len.delete(); log_last.delete();
        log_64b.delete(); log_rise.delete(); log_acc.delete();
        first_rise = -1;
        n_commit   = 0;
        n_dn       = 0;
        m_cur      = {addr[63:3], 3'b000};
        m_remain   = 64'(len & ~32'd7);
        dn_next    = (m_remain == 0);

        @(negedge clk);
        lbuf_addr  = addr;
        lbuf_len   = len;
        lbuf64b    = is64;
        lbuf_en    = 1'b1;
        req_ready  = 1'b0;
        avail_prev = (starve > 0) ? 0 : staged;
        avail_qw   = AW'(avail_prev);

        while (!done && cyc < 1500) begin
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (lbuf_dn !== dn_next) begin
                n_err++;
                $display("FAIL lbuf_dn @%0d: got %b want %b", cyc, lbuf_dn, dn_next);
            end
            n_cmp++;
            if (commit_en !== commit_next) begin
                n_err++;
                $display("FAIL commit_en @%0d: got %b want %b", cyc, commit_en, commit_next);
            end else if (commit_next) begin
                n_cmp++;
                if (commit_qw !== 10'(commit_exp)) begin
                    n_err++;
                    $display("FAIL commit_qw @%0d: got %0d want %0d", cyc, commit_qw, commit_exp);
                end
            end
            if (commit_en === 1'b1) n_commit++;
            if (lbuf_dn === 1'b1) n_dn++;
            if (commit_next) staged -= commit_exp;
            if (dn_next) done = 1;
            dn_next     = 0;
            commit_next = 0;

            if (!done) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy @%0d: got %b want 1", cyc, busy);
                end
            end
            if (starve > 0 && cyc <= starve) begin
                n_cmp++;
                if (req_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL starved_valid @%0d: got %b want 0", cyc, req_valid);
                end
            end

            if (prev_valid && !prev_ready) begin
                n_cmp++;
                if ({req_valid, req_addr, req_len_dw, req_last, req_64b} !==
                    {1'b1, p_addr, p_len, p_last, p_64}) begin
                    n_err++;
                    $display("FAIL req_stable @%0d: got v=%b a=%h l=%0d want v=1 a=%h l=%0d",
                             cyc, req_valid, req_addr, req_len_dw, p_addr, p_len);
                end
            end else if (prev_valid && prev_ready) begin
                n_cmp++;
                if (req_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL valid_drop @%0d: got %b want 0", cyc, req_valid);
                end
            end else if (req_valid === 1'b1) begin
                chunk    = model_chunk(m_cur, m_remain, longint'(avail_prev));
                exp_last = (chunk == m_remain);
                if (first_rise < 0) first_rise = cyc;
                log_rise.push_back(cyc);
                n_cmp++;
                if (avail_prev == 0) begin
                    n_err++;
                    $display("FAIL valid_when_empty @%0d: got valid=1 want valid=0", cyc);
                end
                n_cmp++;
                if (req_addr !== m_cur) begin
                    n_err++;
                    $display("FAIL req_addr @%0d: got %h want %h", cyc, req_addr, m_cur);
                end
                n_cmp++;
                if (req_len_dw !== 10'(chunk / 4)) begin
                    n_err++;
                    $display("FAIL req_len_dw @%0d: got %0d want %0d", cyc, req_len_dw, chunk / 4);
                end
                n_cmp++;
                if (req_last !== exp_last) begin
                    n_err++;
                    $display("FAIL req_last @%0d: got %b want %b", cyc, req_last, exp_last);
                end
                n_cmp++;
                if (req_64b !== is64) begin
                    n_err++;
                    $display("FAIL req_64b @%0d: got %b want %b", cyc, req_64b, is64);
                end
            end

            // Generator side: decide req_ready for the coming edge.
            if (req_valid === 1'b1 && hold_left > 0) begin
                req_ready = 1'b0;
                hold_left--;
            end else begin
                req_ready = ($urandom_range(99) < ready_pct);
            end
            if (req_valid === 1'b1 && req_ready) begin
                log_addr.push_back(m_cur);
                log_len.push_back(int'(chunk / 4));
                log_last.push_back(exp_last);
                log_64b.push_back(req_64b);
                log_acc.push_back(cyc);
                m_cur       += chunk;
                m_remain    -= chunk;
                commit_next  = 1;
                commit_exp   = int'(chunk / 8);
                dn_next      = exp_last;
                hold_left    = hold;
            end
            prev_valid = (req_valid === 1'b1);
            prev_ready = req_ready;
            p_addr = req_addr; p_len = req_len_dw; p_last = req_last; p_64 = req_64b;

            // Staging side: new RX data arrives at random.
            if ($urandom_range(99) < prod_pct) staged += $urandom_range(1, 8);
            avail_prev = (cyc < starve) ? 0 : staged;
            avail_qw   = AW'(avail_prev);
        end

        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL lbuf_timeout: got no lbuf_dn want lbuf_dn within 1500 cycles");
        end

        // One cycle into DRAIN with the grant still up: must stay busy.
        @(negedge clk);
        n_cmp++;
        if ({lbuf_dn, commit_en, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL drain_hold: got dn/ce/busy=%b want 001", {lbuf_dn, commit_en, busy});
        end
        lbuf_en   = 1'b0;
        req_ready = 1'b0;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_release: got %b want 0", busy);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if ({lbuf_dn, commit_en, commit_qw, req_valid, req_addr, req_len_dw,
             req_64b, req_last, busy} !== '0) begin
            n_err++;
            $display("FAIL %s: got dn=%b ce=%b cq=%0d v=%b a=%h l=%0d 64=%b last=%b busy=%b want all 0",
                     tag, lbuf_dn, commit_en, commit_qw, req_valid, req_addr, req_len_dw,
                     req_64b, req_last, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; lbuf_addr = 64'h1000; lbuf_len = 32'd64; lbuf_en = 1'b1;
        lbuf64b = 1'b1; avail_qw = '1; req_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_values");
        lbuf_en = 1'b0; req_ready = 1'b0; avail_qw = '0;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset_idle");
    endtask

    task automatic test_aligned;
        staged = 1000;
        run_lbuf(64'h1000, 32'd512, 1'b0, 100, 0, 0, 0);
        n_cmp++;
        if (log_addr.size() != 4) begin
            n_err++;
            $display("FAIL aligned_count: got %0d want 4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (log_addr[i] !== 64'h1000 + 64'(128 * i) || log_len[i] != 32 ||
                    log_last[i] != (i == 3)) begin
                    n_err++;
                    $display("FAIL aligned_req%0d: got a=%h l=%0d last=%b want a=%h l=32 last=%b",
                             i, log_addr[i], log_len[i], log_last[i], 64'h1000 + 64'(128 * i), i == 3);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (log_rise[i + 1] - log_acc[i] < 3) begin
                    n_err++;
                    $display("FAIL b2b_spacing%0d: got %0d want >=3", i, log_rise[i + 1] - log_acc[i]);
                end
            end
        end
        n_cmp++;
        if (first_rise < 3) begin
            n_err++;
            $display("FAIL first_latency: got %0d want >=3", first_rise);
        end
        n_cmp++;
        if (n_dn != 1) begin
            n_err++;
            $display("FAIL aligned_dn_count: got %0d want 1", n_dn);
        end
    endtask

    task automatic test_page_cross;
        staged = 200;
        run_lbuf(64'h0FF0, 32'd64, 1'b0, 100, 0, 0, 0);
        n_cmp++;
        if (log_addr.size() != 2 || log_addr[0] !== 64'h0FF0 || log_len[0] != 4 ||
            log_addr[1] !== 64'h1000 || log_len[1] != 12) begin
            n_err++;
            $display("FAIL page_cross: got n=%0d want 2 requests 0FF0/4DW and 1000/12DW",
                     log_addr.size());
        end
    endtask

    task automatic test_starvation;
        staged = 4;
        run_lbuf(64'h2000, 32'd32, 1'b0, 100, 0, 0, 20);
        n_cmp++;
        if (log_addr.size() != 1 || log_addr[0] !== 64'h2000 || log_len[0] != 8 ||
            !log_last[0]) begin
            n_err++;
            $display("FAIL starvation: got n=%0d want one 8DW last request at 2000", log_addr.size());
        end
    endtask

    task automatic test_backpressure;
        staged = 100;
        run_lbuf(64'h3000, 32'd64, 1'b0, 100, 7, 0, 0);
        n_cmp++;
        if (log_addr.size() != 1 || log_len[0] != 16 || log_acc[0] - log_rise[0] != 7) begin
            n_err++;
            $display("FAIL backpressure: got n=%0d want one 16DW request held 7 cycles",
                     log_addr.size());
        end
        n_cmp++;
        if (n_commit != 1) begin
            n_err++;
            $display("FAIL bp_commit_count: got %0d want 1", n_commit);
        end
    endtask

    task automatic test_zero_len;
        staged = 50;
        run_lbuf(64'h7000, 32'd0, 1'b0, 100, 0, 0, 0);
        n_cmp++;
        if (log_addr.size() != 0 || n_dn != 1) begin
            n_err++;
            $display("FAIL zero_len: got reqs=%0d dn=%0d want reqs=0 dn=1", log_addr.size(), n_dn);
        end
        run_lbuf(64'h7008, 32'd7, 1'b0, 100, 0, 0, 0);
        n_cmp++;
        if (log_addr.size() != 0 || n_dn != 1) begin
            n_err++;
            $display("FAIL sub_qword_len: got reqs=%0d dn=%0d want reqs=0 dn=1", log_addr.size(), n_dn);
        end
    endtask

    task automatic test_64b;
        staged = 50;
        run_lbuf(64'h1_0000_0FF8, 32'd16, 1'b1, 100, 0, 0, 0);
        n_cmp++;
        if (log_addr.size() != 2 || log_addr[0] !== 64'h1_0000_0FF8 ||
            log_addr[1] !== 64'h1_0000_1000 || log_len[0] != 2 || log_len[1] != 2 ||
            !log_64b[0] || !log_64b[1]) begin
            n_err++;
            $display("FAIL addr64_page: got n=%0d want 1_0000_0FF8 and 1_0000_1000, 2DW, 64b",
                     log_addr.size());
        end
        staged = 50;
        run_lbuf(64'h0000_0000_FFFF_FFF8, 32'd16, 1'b1, 100, 0, 0, 0);
        n_cmp++;
        if (log_addr.size() != 2 || log_addr[1] !== 64'h1_0000_0000) begin
            n_err++;
            $display("FAIL addr_carry: got n=%0d want second request at 1_0000_0000",
                     log_addr.size());
        end
    endtask

    task automatic test_reset_mid;
        int cyc = 0;
        @(negedge clk);
        lbuf_addr = 64'h5000; lbuf_len = 32'd256; lbuf64b = 1'b1; lbuf_en = 1'b1;
        avail_qw = AW'(100); req_ready = 1'b0;
        while (req_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_setup: got valid=%b want 1", req_valid);
        end
        req_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_in_issue");
        rst = 1'b0; lbuf_en = 1'b0; req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({commit_en, lbuf_dn, req_valid, busy} !== 4'b0000) begin
                n_err++;
                $display("FAIL post_reset_quiet%0d: got ce/dn/v/busy=%b want 0000",
                         i, {commit_en, lbuf_dn, req_valid, busy});
            end
        end
        staged = 100;
        run_lbuf(64'h6000, 32'd256, 1'b0, 100, 0, 0, 0);
        n_cmp++;
        if (log_addr.size() != 2 || log_addr[0] !== 64'h6000 || log_addr[1] !== 64'h6080) begin
            n_err++;
            $display("FAIL reset_recover: got n=%0d want 2 requests at 6000/6080", log_addr.size());
        end
    endtask

    task automatic test_random;
        logic [63:0] addr;
        logic [31:0] len;
        for (int n = 0; n < 12; n++) begin
            addr = {32'($urandom), 32'($urandom)};
            if ($urandom_range(1) == 0) addr[63:32] = '0;
            if ($urandom_range(1) == 0) addr[11:0] = 12'hF00 + 12'($urandom_range(255));
            len    = 32'($urandom_range(1200));
            staged = $urandom_range(30);
            run_lbuf(addr, len, addr[63:32] != 0, 30 + int'($urandom_range(70)),
                     int'($urandom_range(3)), 40, 0);
        end
    endtask

    initial begin
        rst = 1'b1; lbuf_addr = '0; lbuf_len = '0; lbuf_en = 1'b0; lbuf64b = 1'b0;
        avail_qw = '0; req_ready = 1'b0; staged = 0;
        test_reset();
        test_aligned();
        test_page_cross();
        test_starvation();
        test_backpressure();
        test_zero_len();
        test_64b();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of run want summary before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
